// File: rtl/acs_pmu.sv
// Add-compare-select / path-metric unit for a K=3, rate-1/2 Viterbi decoder (g0=111, g1=101).
// Seeds four path metrics from the branch-metric chain, then runs one ACS step per received pair.
module acs_pmu #(
  parameter int unsigned PM_W      = 6,
  parameter int unsigned FRAME_LEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            refresh,
  input  logic            seed_valid,
  input  logic [3:0]      bm_000,
  input  logic [3:0]      bm_001,
  input  logic [3:0]      bm_010,
  input  logic [3:0]      bm_011,
  input  logic [3:0]      bm_100,
  input  logic [3:0]      bm_101,
  input  logic [3:0]      bm_110,
  input  logic [3:0]      bm_111,
  input  logic            sym_valid,
  input  logic [1:0]      rx_pair,
  output logic [PM_W-1:0] pm0,
  output logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] pm2,
  output logic [PM_W-1:0] pm3,
  output logic [3:0]      decision,
  output logic [1:0]      best_state,
  output logic            valid_out,
  output logic            frame_done
);

  localparam int unsigned MW        = PM_W + 1;
  localparam logic [7:0]  LAST_STEP = 8'(FRAME_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [PM_W-1:0] pm_q [4];
  logic [PM_W-1:0] pm_d [4];
  logic [3:0]      dec_q, dec_d;
  logic [1:0]      best_q, best_d;
  logic            valid_q, done_q;

  logic [3:0]      bm [8];
  logic [3:0]      cand [4];
  logic [3:0]      cand_min;
  logic [PM_W-1:0] seed_pm [4];
  logic [3:0]      seed_dec;

  logic [1:0]      st;
  logic            b, u;
  logic [1:0]      hd0, hd1;
  logic [MW-1:0]   m0, m1, norm, acs_min;
  logic [MW-1:0]   acs_new [4];
  logic [PM_W-1:0] acs_pm [4];
  logic [3:0]      acs_dec;

  assign bm[0] = bm_000;
  assign bm[1] = bm_001;
  assign bm[2] = bm_010;
  assign bm[3] = bm_011;
  assign bm[4] = bm_100;
  assign bm[5] = bm_101;
  assign bm[6] = bm_110;
  assign bm[7] = bm_111;

  // Seed: state {y,z} keeps the cheaper of the two candidate paths x=0 / x=1.
  always_comb begin
    cand_min = '1;
    seed_dec = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      seed_dec[s] = bm[s + 4] < bm[s];
      cand[s]     = seed_dec[s] ? bm[s + 4] : bm[s];
      if (cand[s] < cand_min) cand_min = cand[s];
    end
    for (int unsigned s = 0; s < 4; s++) begin
      seed_pm[s] = PM_W'(cand[s] - cand_min);
    end
  end

  // ACS: predecessors of {b,u} are {0,b} and {1,b}; expected code c0=u^b^a, c1=u^a.
  always_comb begin
    st      = '0;
    b       = 1'b0;
    u       = 1'b0;
    hd0     = '0;
    hd1     = '0;
    m0      = '0;
    m1      = '0;
    norm    = '0;
    acs_min = '1;
    acs_dec = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      st  = 2'(s);
      b   = st[1];
      u   = st[0];
      hd0 = {1'b0, rx_pair[1] ^ u ^ b} + {1'b0, rx_pair[0] ^ u};
      hd1 = {1'b0, ~(rx_pair[1] ^ u ^ b)} + {1'b0, ~(rx_pair[0] ^ u)};
      m0  = {1'b0, pm_q[{1'b0, b}]} + MW'(hd0);
      m1  = {1'b0, pm_q[{1'b1, b}]} + MW'(hd1);
      acs_dec[s] = m1 < m0;
      acs_new[s] = acs_dec[s] ? m1 : m0;
      if (acs_new[s] < acs_min) acs_min = acs_new[s];
    end
    for (int unsigned s = 0; s < 4; s++) begin
      norm      = acs_new[s] - acs_min;
      acs_pm[s] = norm[PM_W] ? '1 : norm[PM_W-1:0];
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < 4; s++) begin
      pm_d[s] = (state_q == IDLE) ? seed_pm[s] : acs_pm[s];
    end
    dec_d  = (state_q == IDLE) ? seed_dec : acs_dec;
    best_d = '0;
    for (int unsigned s = 1; s < 4; s++) begin
      if (pm_d[s] < pm_d[best_d]) best_d = 2'(s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pm_q    <= '{default: '0};
      dec_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (refresh) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pm_q    <= '{default: '0};
      dec_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seed_valid) begin
            pm_q    <= pm_d;
            dec_q   <= dec_d;
            best_q  <= best_d;
            valid_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (sym_valid) begin
            pm_q    <= pm_d;
            dec_q   <= dec_d;
            best_q  <= best_d;
            valid_q <= 1'b1;
            if (cnt_q == LAST_STEP) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pm0        = pm_q[0];
  assign pm1        = pm_q[1];
  assign pm2        = pm_q[2];
  assign pm3        = pm_q[3];
  assign decision   = dec_q;
  assign best_state = best_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule
